// File: rtl/counter_pkg.sv
// Shared definitions for the counter slice.
// Default width and the matching count type.
package counter_pkg;

   localparam int WIDTH_DEFAULT = 8;

   typedef logic [WIDTH_DEFAULT-1:0] count_t;

   // Reduce a step amount to the counter width.
   function automatic logic [31:0] step_mod(
      input int step,
      input int width
   );
      logic [31:0] mask;
      mask = (width >= 32) ? 32'hFFFF_FFFF
                           : ((32'd1 << width) - 32'd1);
      return 32'(step) & mask;
   endfunction

endpackage

// File: rtl/counter_next.sv
// Combinational next-count and wrap logic.
// Priority: clear, load, enabled step, hold.
module counter_next
   import counter_pkg::*;
#(
   parameter int                WIDTH       = WIDTH_DEFAULT,
   parameter int                STEP        = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic [WIDTH-1:0] count,
   input  logic             en,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             down,
   output logic [WIDTH-1:0] next_count,
   output logic             next_wrap
);

   localparam logic [31:0]      STEP_M = step_mod(STEP, WIDTH);
   localparam logic [WIDTH-1:0] STEP_W = STEP_M[WIDTH-1:0];
   localparam logic [WIDTH:0]   STEP_X = {1'b0, STEP_W};

   logic [WIDTH:0] sum;
   logic [WIDTH:0] diff;

   // Carry/borrow land in the extra top bit and flag the wrap.
   always_comb begin
      sum        = {1'b0, count} + STEP_X;
      diff       = {1'b0, count} - STEP_X;
      next_count = count;
      next_wrap  = 1'b0;
      if (clr) begin
         next_count = RESET_VALUE;
      end else if (load) begin
         next_count = load_value;
      end else if (en) begin
         if (down) begin
            next_count = diff[WIDTH-1:0];
            next_wrap  = diff[WIDTH];
         end else begin
            next_count = sum[WIDTH-1:0];
            next_wrap  = sum[WIDTH];
         end
      end
   end

endmodule

// File: rtl/counter_8bit.sv
// Free-running up/down counter with wrap pulse.
// Holds the count and wrap registers only.
module counter_8bit
   import counter_pkg::*;
#(
   parameter int                WIDTH       = WIDTH_DEFAULT,
   parameter int                STEP        = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst_n      = 1'b1,
   input  logic             en         = 1'b1,
   input  logic             clr        = 1'b0,
   input  logic             load       = 1'b0,
   input  logic [WIDTH-1:0] load_value = '0,
   input  logic             down       = 1'b0,
   output logic [WIDTH-1:0] counter_output,
   output logic             wrap
);

   logic [WIDTH-1:0] next_count;
   logic             next_wrap;

   counter_next #(
      .WIDTH       (WIDTH),
      .STEP        (STEP),
      .RESET_VALUE (RESET_VALUE)
   ) u_next (
      .count      (counter_output),
      .en         (en),
      .clr        (clr),
      .load       (load),
      .load_value (load_value),
      .down       (down),
      .next_count (next_count),
      .next_wrap  (next_wrap)
   );

   // Count and wrap registers; reset drops them at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         counter_output <= RESET_VALUE;
         wrap           <= 1'b0;
      end else begin
         counter_output <= next_count;
         wrap           <= next_wrap;
      end
   end

endmodule

// File: tb/tb_counter_8bit.sv
// Directed test of counter_8bit, default and
// a 4-bit step-3 instance.
`timescale 1ns/100ps
module tb_counter_8bit;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       clr;
   logic       load;
   logic [7:0] load_value;
   logic       down;
   logic [7:0] count;
   logic       wrap;

   logic       rst4_n;
   logic [3:0] count4;
   logic       wrap4;

   int checks = 0;
   int passed = 0;

   counter_8bit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .en             (en),
      .clr            (clr),
      .load           (load),
      .load_value     (load_value),
      .down           (down),
      .counter_output (count),
      .wrap           (wrap)
   );

   counter_8bit #(
      .WIDTH (4),
      .STEP  (3)
   ) dut4 (
      .clk            (clk),
      .rst_n          (rst4_n),
      .en             (1'b1),
      .clr            (1'b0),
      .load           (1'b0),
      .load_value     (4'h0),
      .down           (1'b0),
      .counter_output (count4),
      .wrap           (wrap4)
   );

   initial clk = 1'b1;
   always #1 clk = ~clk;

   task automatic check(
      input string       tag,
      input logic [31:0] obs,
      input logic [31:0] exp
   );
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h",
                  tag, obs, exp);
   endtask

   task automatic edges(input int n);
      repeat (n) @(negedge clk);
   endtask

   logic [3:0] seq4 [6] = '{4'd3, 4'd6, 4'd9,
                            4'd12, 4'd15, 4'd2};
   logic       wr4  [6] = '{1'b0, 1'b0, 1'b0,
                            1'b0, 1'b0, 1'b1};

   initial begin
      rst_n      = 1'b0;
      rst4_n     = 1'b0;
      en         = 1'b1;
      clr        = 1'b0;
      load       = 1'b0;
      load_value = 8'h00;
      down       = 1'b0;

      edges(1);
      check("reset_count", 32'(count), 32'd0);
      check("reset_wrap", 32'(wrap), 32'd0);
      rst_n = 1'b1;

      edges(1);
      check("free_1", 32'(count), 32'd1);
      edges(9);
      check("free_10", 32'(count), 32'd10);

      edges(245);
      check("pre_wrap_cnt", 32'(count), 32'd255);
      check("pre_wrap_flag", 32'(wrap), 32'd0);
      edges(1);
      check("wrap_cnt", 32'(count), 32'd0);
      check("wrap_flag", 32'(wrap), 32'd1);
      edges(1);
      check("post_wrap_cnt", 32'(count), 32'd1);
      check("post_wrap_flag", 32'(wrap), 32'd0);

      edges(36);
      check("at_37", 32'(count), 32'd37);
      #0.2 rst_n = 1'b0;
      #0.2;
      check("async_rst", 32'(count), 32'd0);
      #0.2 rst_n = 1'b1;
      edges(1);
      check("rst_release", 32'(count), 32'd1);

      edges(4);
      check("at_5", 32'(count), 32'd5);
      clr        = 1'b1;
      load       = 1'b1;
      load_value = 8'hA0;
      edges(1);
      check("clr_over_load", 32'(count), 32'd0);
      clr = 1'b0;
      edges(1);
      check("load_a0", 32'(count), 32'hA0);
      check("load_wrap", 32'(wrap), 32'd0);
      load = 1'b0;
      en   = 1'b0;
      edges(3);
      check("hold_a0", 32'(count), 32'hA0);
      check("hold_wrap", 32'(wrap), 32'd0);

      load       = 1'b1;
      load_value = 8'h55;
      edges(1);
      check("load_no_en", 32'(count), 32'h55);
      load = 1'b0;
      clr  = 1'b1;
      edges(1);
      check("clr_no_en", 32'(count), 32'd0);
      clr = 1'b0;
      en  = 1'b1;

      load       = 1'b1;
      load_value = 8'h01;
      edges(1);
      check("load_1", 32'(count), 32'd1);
      load = 1'b0;
      down = 1'b1;
      edges(1);
      check("down_0", 32'(count), 32'd0);
      check("down_0_wrap", 32'(wrap), 32'd0);
      edges(1);
      check("down_255", 32'(count), 32'd255);
      check("down_255_wrap", 32'(wrap), 32'd1);
      edges(1);
      check("down_254", 32'(count), 32'd254);
      check("down_254_wrap", 32'(wrap), 32'd0);

      check("w4_reset", 32'(count4), 32'd0);
      rst4_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         edges(1);
         check($sformatf("w4_cnt_%0d", i),
               32'(count4), 32'(seq4[i]));
         check($sformatf("w4_wrap_%0d", i),
               32'(wrap4), 32'(wr4[i]));
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
